// File: rtl/io_bridge.sv
// CPU load/store bridge: splits the unified address space between data RAM and a
// small peripheral block (seven-segment value, timer, LEDs, switches, buttons).
module io_bridge #(
    parameter logic [31:0] DRAM_BASE = 32'h0000_4000,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_F000,
    parameter logic [15:0] TIMER_DIV = 16'd10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        dram_we,
    output logic [13:0] dram_addr,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [31:0] seg_data
);

    localparam int unsigned SW_W  = 24;
    localparam int unsigned BTN_W = 5;
    localparam int unsigned PRE_W = 16;

    localparam logic [31:0] OFF_SEG   = 32'h0000_0000;
    localparam logic [31:0] OFF_TIMER = 32'h0000_0020;
    localparam logic [31:0] OFF_LED   = 32'h0000_0060;
    localparam logic [31:0] OFF_SW    = 32'h0000_0070;
    localparam logic [31:0] OFF_BTN   = 32'h0000_0078;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMER_DIV - 16'd1);

    logic             dram_sel;
    logic             io_sel;
    logic [31:0]      dram_off;
    logic [31:0]      io_off;
    logic             we_seg;
    logic             we_timer;
    logic             we_led;
    logic             tick;
    logic             unused_dram_off;

    logic [31:0]      seg_q, seg_d;
    logic [SW_W-1:0]  led_q, led_d;
    logic [31:0]      timer_q, timer_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SW_W-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [BTN_W-1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;

    // Address decode; register writes only hit exact offsets.
    always_comb begin
        dram_off = cpu_addr - DRAM_BASE;
        io_off   = cpu_addr - IO_BASE;
        dram_sel = (cpu_addr >= DRAM_BASE) && (cpu_addr < IO_BASE);
        io_sel   = (cpu_addr >= IO_BASE);
        we_seg   = cpu_we && io_sel && (io_off == OFF_SEG);
        we_timer = cpu_we && io_sel && (io_off == OFF_TIMER);
        we_led   = cpu_we && io_sel && (io_off == OFF_LED);
    end

    assign dram_addr       = dram_off[15:2];
    assign dram_wdata      = cpu_wdata;
    assign dram_we         = cpu_we && dram_sel;
    assign unused_dram_off = ^{dram_off[31:16], dram_off[1:0]};

    // Next state: a timer write outranks a simultaneous tick.
    always_comb begin
        tick       = (pre_q == PRE_LAST);
        seg_d      = seg_q;
        led_d      = led_q;
        timer_d    = timer_q;
        pre_d      = tick ? '0 : pre_q + PRE_W'(1);
        sw_meta_d  = sw;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = btn;
        btn_sync_d = btn_meta_q;
        if (we_seg) begin
            seg_d = cpu_wdata;
        end
        if (we_led) begin
            led_d = cpu_wdata[SW_W-1:0];
        end
        if (we_timer) begin
            timer_d = cpu_wdata;
            pre_d   = '0;
        end else if (tick) begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            led_q      <= '0;
            timer_q    <= '0;
            pre_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            seg_q      <= seg_d;
            led_q      <= led_d;
            timer_q    <= timer_d;
            pre_q      <= pre_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
        end
    end

    // Zero-latency load mux.
    always_comb begin
        cpu_rdata = '0;
        if (dram_sel) begin
            cpu_rdata = dram_rdata;
        end else if (io_sel) begin
            case (io_off)
                OFF_SEG:   cpu_rdata = seg_q;
                OFF_TIMER: cpu_rdata = timer_q;
                OFF_LED:   cpu_rdata = 32'(led_q);
                OFF_SW:    cpu_rdata = 32'(sw_sync_q);
                OFF_BTN:   cpu_rdata = 32'(btn_sync_q);
                default:   cpu_rdata = '0;
            endcase
        end
    end

    assign seg_data = seg_q;
    assign led      = led_q;

endmodule

// File: tb/tb_io_bridge.sv
// Bench for io_bridge: directed scenarios then random loads/stores, checked against
// an abstract model (timer = last load + elapsed cycles / divider).
module tb_io_bridge;

    localparam logic [31:0] DRAM_BASE = 32'h0000_4000;
    localparam logic [31:0] IO_BASE   = 32'hFFFF_F000;
    localparam int unsigned TDIV      = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dram_we;
    logic [13:0] dram_addr;
    logic [31:0] dram_wdata, dram_rdata;
    logic [23:0] sw, led;
    logic [4:0]  btn;
    logic [31:0] seg_data;

    logic [31:0] rd1, dram_wdata1, seg_data1;
    logic        dram_we1;
    logic [13:0] dram_addr1;
    logic [23:0] led1;

    io_bridge #(.DRAM_BASE(DRAM_BASE), .IO_BASE(IO_BASE), .TIMER_DIV(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dram_we(dram_we),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
        .sw(sw), .btn(btn), .led(led), .seg_data(seg_data)
    );

    // Divider of 1: timer register should advance on every edge.
    io_bridge #(.DRAM_BASE(DRAM_BASE), .IO_BASE(IO_BASE), .TIMER_DIV(16'd1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cpu_we(1'b0), .cpu_addr(IO_BASE + 32'h20),
        .cpu_wdata(32'h0), .cpu_rdata(rd1), .dram_we(dram_we1),
        .dram_addr(dram_addr1), .dram_wdata(dram_wdata1), .dram_rdata(32'h0),
        .sw(24'h0), .btn(5'h0), .led(led1), .seg_data(seg_data1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int unsigned i);
        return 32'h5A00_0000 ^ 32'(i * 32'h9E37);
    endfunction

    logic [31:0] ram [0:16383];
    initial for (int i = 0; i < 16384; i++) ram[i] = pat(i);
    assign dram_rdata = ram[dram_addr];
    always @(posedge clk) if (dram_we) ram[dram_addr] <= dram_wdata;

    // Model state
    logic [31:0] mdram [int unsigned];
    logic [31:0] m_seg, m_tload;
    logic [23:0] m_led, m_sw_meta, m_sw_sync;
    logic [4:0]  m_btn_meta, m_btn_sync;
    int unsigned m_tcyc, m_cyc1;
    int unsigned n_cmp = 0, n_err = 0;

    function automatic int unsigned widx(input logic [31:0] a);
        return ((a - DRAM_BASE) >> 2) & 32'h3FFF;
    endfunction

    function automatic logic [31:0] m_timer();
        return m_tload + 32'(m_tcyc / TDIV);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a >= IO_BASE) begin
            case (a - IO_BASE)
                32'h00:  return m_seg;
                32'h20:  return m_timer();
                32'h60:  return {8'h0, m_led};
                32'h70:  return {8'h0, m_sw_sync};
                32'h78:  return {27'h0, m_btn_sync};
                default: return 32'h0;
            endcase
        end else if (a >= DRAM_BASE) begin
            return mdram.exists(widx(a)) ? mdram[widx(a)] : pat(widx(a));
        end
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_seg = 0; m_led = 0; m_tload = 0; m_tcyc = 0; m_cyc1 = 0;
        m_sw_meta = 0; m_sw_sync = 0; m_btn_meta = 0; m_btn_sync = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic dsel;
        dsel = (cpu_addr >= DRAM_BASE) && (cpu_addr < IO_BASE);
        chk({tag, "_rdata"}, cpu_rdata, exp_rd(cpu_addr));
        chk({tag, "_dram_we"}, 32'(dram_we), 32'(cpu_we && dsel));
        chk({tag, "_dram_addr"}, 32'(dram_addr), 32'(((cpu_addr - DRAM_BASE) >> 2) & 32'h3FFF));
        chk({tag, "_dram_wdata"}, dram_wdata, cpu_wdata);
        chk({tag, "_seg"}, seg_data, m_seg);
        chk({tag, "_led"}, 32'(led), 32'(m_led));
        chk({tag, "_timer_div1"}, rd1, m_cyc1);
    endtask

    task automatic set_in(input logic we, input logic [31:0] a, input logic [31:0] wd);
        cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        #1;
    endtask

    // One clock: capture pre-edge inputs, apply the edge to the model, return at negedge.
    task automatic cyc();
        logic        we;
        logic [31:0] a, wd;
        logic [23:0] s;
        logic [4:0]  b;
        we = cpu_we; a = cpu_addr; wd = cpu_wdata; s = sw; b = btn;
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else begin
            m_sw_sync = m_sw_meta; m_sw_meta = s;
            m_btn_sync = m_btn_meta; m_btn_meta = b;
            if (we && a >= DRAM_BASE && a < IO_BASE) mdram[widx(a)] = wd;
            if (we && a == IO_BASE) m_seg = wd;
            if (we && a == IO_BASE + 32'h60) m_led = wd[23:0];
            if (we && a == IO_BASE + 32'h20) begin
                m_tload = wd; m_tcyc = 0;
            end else begin
                m_tcyc++;
            end
            m_cyc1++;
        end
        @(negedge clk);
    endtask

    logic [31:0] offs [0:8];

    initial begin
        offs[0] = 32'h00; offs[1] = 32'h20; offs[2] = 32'h60; offs[3] = 32'h70;
        offs[4] = 32'h78; offs[5] = 32'h04; offs[6] = 32'h24; offs[7] = 32'h7C;
        offs[8] = 32'h61;
        m_reset();
        rst_n = 1'b0; sw = 0; btn = 0;
        set_in(0, IO_BASE + 32'h20, 0);
        #1;
        check_all("reset");
        chk("reset_timer", cpu_rdata, 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Timer with divider 4 from reset, then a write landing on the tick.
        set_in(0, IO_BASE + 32'h20, 0);
        repeat (3) cyc();
        set_in(0, IO_BASE + 32'h20, 0);
        chk("tmr_pre1", cpu_rdata, 32'h0);
        cyc(); set_in(0, IO_BASE + 32'h20, 0);
        chk("tmr_1", cpu_rdata, 32'h1);
        repeat (4) cyc(); set_in(0, IO_BASE + 32'h20, 0);
        chk("tmr_2", cpu_rdata, 32'h2);
        check_all("tmr_2m");
        repeat (3) cyc();
        set_in(1, IO_BASE + 32'h20, 32'hFFFF_FFFF);
        cyc(); set_in(0, IO_BASE + 32'h20, 0);
        chk("tmr_wr_wins", cpu_rdata, 32'hFFFF_FFFF);
        repeat (3) cyc(); set_in(0, IO_BASE + 32'h20, 0);
        chk("tmr_hold", cpu_rdata, 32'hFFFF_FFFF);
        cyc(); set_in(0, IO_BASE + 32'h20, 0);
        chk("tmr_wrap", cpu_rdata, 32'h0);
        check_all("tmr_wrap_m");

        // DRAM store and load.
        set_in(1, 32'h0000_4008, 32'h2500_0018);
        check_all("dram_st");
        chk("dram_st_we", 32'(dram_we), 32'h1);
        chk("dram_st_addr", 32'(dram_addr), 32'd2);
        cyc(); set_in(0, 32'h0000_4008, 0);
        chk("dram_ld", cpu_rdata, 32'h2500_0018);

        // SEG and LED stores with read-back.
        set_in(1, IO_BASE, 32'hDEAD_BEEF);
        chk("seg_st_we", 32'(dram_we), 32'h0);
        cyc();
        chk("seg_val", seg_data, 32'hDEAD_BEEF);
        set_in(1, IO_BASE + 32'h60, 32'h00AB_CDEF);
        chk("led_st_we", 32'(dram_we), 32'h0);
        cyc();
        chk("led_val", 32'(led), 32'h00AB_CDEF);
        set_in(0, IO_BASE, 0);
        chk("seg_rd", cpu_rdata, 32'hDEAD_BEEF);
        set_in(0, IO_BASE + 32'h60, 0);
        chk("led_rd", cpu_rdata, 32'h00AB_CDEF);

        // Switch / button synchronizer latency.
        set_in(0, IO_BASE + 32'h70, 0);
        sw = 24'h00F00F;
        #1;
        chk("sw_pre", cpu_rdata, 32'h0);
        cyc(); set_in(0, IO_BASE + 32'h70, 0);
        chk("sw_edge1", cpu_rdata, 32'h0);
        cyc(); set_in(0, IO_BASE + 32'h70, 0);
        chk("sw_edge2", cpu_rdata, 32'h0000_F00F);
        btn = 5'b10001;
        set_in(0, IO_BASE + 32'h78, 0);
        cyc(); cyc(); set_in(0, IO_BASE + 32'h78, 0);
        chk("btn_rd", cpu_rdata, 32'h0000_0011);

        // Unmapped, undefined offset and read-only write.
        set_in(1, IO_BASE + 32'h70, 32'h1234);
        cyc();
        set_in(0, 32'h0000_0100, 0);
        chk("unmapped_rd", cpu_rdata, 32'h0);
        set_in(0, IO_BASE + 32'h04, 0);
        chk("undef_rd", cpu_rdata, 32'h0);
        set_in(0, IO_BASE + 32'h70, 0);
        chk("ro_rd", cpu_rdata, 32'h0000_F00F);
        check_all("ro_m");

        // Async reset with TIMER=5 and SEG/LED loaded.
        set_in(1, IO_BASE + 32'h20, 32'h5);
        cyc();
        set_in(0, IO_BASE + 32'h20, 0);
        chk("pre_rst_timer", cpu_rdata, 32'h5);
        rst_n = 1'b0;
        #1;
        chk("arst_seg", seg_data, 32'h0);
        chk("arst_led", 32'(led), 32'h0);
        chk("arst_timer", cpu_rdata, 32'h0);
        chk("arst_timer1", rd1, 32'h0);
        m_reset();
        rst_n = 1'b1;
        repeat (3) cyc(); set_in(0, IO_BASE + 32'h20, 0);
        chk("rst_tmr_pre", cpu_rdata, 32'h0);
        cyc(); set_in(0, IO_BASE + 32'h20, 0);
        chk("rst_tmr_1", cpu_rdata, 32'h1);
        check_all("rst_m");

        // Random mix of loads and stores across all regions.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, wd;
            case ($urandom_range(0, 3))
                0: a = DRAM_BASE + 32'($urandom_range(0, 1023));
                1: a = IO_BASE + offs[$urandom_range(0, 8)];
                2: a = 32'($urandom_range(0, 32'h3FFF));
                default: a = IO_BASE - 32'($urandom_range(1, 16));
            endcase
            wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2))
                                             : 32'($urandom);
            if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
            if ($urandom_range(0, 3) == 0) btn = 5'($urandom);
            set_in($urandom_range(0, 2) == 0, a, wd);
            check_all("rand");
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter DRAM_BASE, 32'h0000_4000, start of the data RAM window in the unified address space.
REQ-002 Parameter IO_BASE, 32'hFFFF_F000, start of the peripheral window and end of the DRAM window.
REQ-003 Parameter TIMER_DIV, 16'd10000, clk cycles per timer increment (1 kHz at 10 MHz).
REQ-004 clk  input  1  CPU/data-memory clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cpu_we  input  1  CPU store strobe.
REQ-007 cpu_addr  input  32  CPU byte address (ALU result).
REQ-008 cpu_wdata  input  32  CPU store data.
REQ-009 cpu_rdata  output  32  load data returned to the CPU.
REQ-010 dram_we  output  1  data RAM write enable.
REQ-011 dram_addr  output  14  data RAM word address.
REQ-012 dram_wdata  output  32  data RAM write data.
REQ-013 dram_rdata  input  32  data RAM asynchronous read data.
REQ-014 sw  input  24  board switches, asynchronous to clk.
REQ-015 btn  input  5  board buttons, asynchronous to clk.
REQ-016 led  output  24  board LEDs.
REQ-017 seg_data  output  32  value for the seven-segment display driver.

Function
REQ-018 DRAM select SHALL be DRAM_BASE <= cpu_addr < IO_BASE (unsigned); IO select SHALL be cpu_addr >= IO_BASE; all other addresses are unmapped.
REQ-019 dram_addr SHALL be bits [15:2] of (cpu_addr - DRAM_BASE), computed combinationally regardless of select.
REQ-020 dram_wdata SHALL equal cpu_wdata; dram_we SHALL be cpu_we AND DRAM select.
REQ-021 IO register map (offset from IO_BASE): 0x00 SEG RW 32b; 0x20 TIMER RW 32b; 0x60 LED RW 24b; 0x70 SW RO 24b; 0x78 BTN RO 5b.
REQ-022 IO writes SHALL only match the exact offsets above; writes to other IO offsets, unmapped addresses, or RO registers SHALL be ignored.
REQ-023 cpu_rdata SHALL be combinational, zero latency: dram_rdata on DRAM select; the addressed register zero-extended on IO select; 0 for unmapped addresses or undefined IO offsets.
REQ-024 SEG/LED SHALL capture cpu_wdata (LED: bits [23:0]) on the clk edge where cpu_we and their offset match; seg_data and led SHALL drive the register contents directly.
REQ-025 Prescaler SHALL count 0..TIMER_DIV-1 and wrap to 0; the tick SHALL assert for one cycle when the prescaler equals TIMER_DIV-1.
REQ-026 TIMER SHALL increment by 1 on each tick, wrapping 32'hFFFF_FFFF -> 0.
REQ-027 A TIMER write SHALL load cpu_wdata and clear the prescaler to 0; a write in the same cycle as a tick SHALL win, so no increment occurs.
REQ-028 sw and btn SHALL each pass through a two-flop synchronizer; the SW/BTN reads SHALL return the second-stage value, so a change is visible after the second rising edge.
REQ-029 TIMER_DIV = 1 SHALL give a tick every cycle.

Reset
REQ-030 While rst_n = 0: SEG, LED, TIMER, prescaler and all synchronizer flops SHALL be 0, independent of clk; seg_data = 0 and led = 0.
REQ-031 Reset asserted mid-count SHALL discard the prescaler and TIMER values; after release, counting SHALL restart from 0, first tick TIMER_DIV cycles later.
REQ-032 Combinational paths (dram_we, dram_addr, dram_wdata, cpu_rdata mux) SHALL be unaffected by reset other than through register contents.

Verification
REQ-033 Write cpu_addr=32'h0000_4008, data 32'h2500_0018 -> dram_we=1 and dram_addr=14'd2 in that cycle; a load from the same address returns the dram_rdata model value.
REQ-034 Store 32'hDEAD_BEEF to IO_BASE+0x00, then store 32'h00AB_CDEF to IO_BASE+0x60 -> seg_data=32'hDEAD_BEEF and led=24'hABCDEF from the next edge; read back both; dram_we=0 throughout.
REQ-035 TIMER_DIV=4: after reset, TIMER reads 1 after 4 cycles and 2 after 8; write 32'hFFFF_FFFF in the cycle the tick occurs -> TIMER=32'hFFFF_FFFF, then 0 four cycles later.
REQ-036 sw goes 0 -> 24'h00F00F mid-cycle -> SW read = 0 after the first edge and 24'h00F00F after the second; btn=5'b10001 -> BTN read = 32'h0000_0011.
REQ-037 Read 32'h0000_0100, IO_BASE+0x04 and IO_BASE+0x70 after writing 32'h1234 to IO_BASE+0x70 -> first two reads 0, third read = synced switches; SEG/LED/TIMER unchanged.
REQ-038 Assert rst_n=0 asynchronously with TIMER=5, SEG and LED nonzero -> all clear immediately without a clk edge; after release, TIMER=1 after exactly TIMER_DIV cycles.
